// File: rtl/dram_read_frame.sv
// Frame fetcher: streams one frame from MPMC NPI in 16-word read bursts into a dual-clock FIFO.
// Latency: request to first local push is the MPMC latency plus RdFIFO_Latency (0-2) cycles.
// Backpressure: a new burst is requested only when 16 free FIFO slots are guaranteed.

// Dual-clock FWFT FIFO with gray-coded pointers; the write-side reset is carried into the read domain.
// Latency: a written word is visible on rd_dat about 3 rd_clk cycles after the write.
// Backpressure: the writer must respect wr_cnt; rd_rdy is ignored while rd_empty is high.
module dram_read_frame_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 512
) (
    input  logic                         wr_clk,
    input  logic                         wr_rst,
    input  logic                         wr_vld,
    input  logic [W-1:0]                 wr_dat,
    output logic [$clog2(DEPTH):0]       wr_cnt,
    input  logic                         rd_clk,
    input  logic                         rd_rdy,
    output logic [W-1:0]                 rd_dat,
    output logic                         rd_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_bin, wr_gray, wr_bin_nxt;
    logic [AW:0]  rd_bin, rd_gray, rd_bin_nxt;
    logic [AW:0]  rd_gray_s1, rd_gray_s2, wr_gray_s1, wr_gray_s2;
    logic         rd_rst_s1, rd_rst;

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    assign wr_bin_nxt = wr_bin + 1'b1;
    assign rd_bin_nxt = rd_bin + 1'b1;
    assign wr_cnt     = wr_bin - gray2bin(rd_gray_s2);

    always_ff @(posedge wr_clk) begin
        if (wr_vld && !wr_rst) mem[wr_bin[AW-1:0]] <= wr_dat;
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wr_bin     <= '0;
            wr_gray    <= '0;
            rd_gray_s1 <= '0;
            rd_gray_s2 <= '0;
        end else begin
            if (wr_vld) begin
                wr_bin  <= wr_bin_nxt;
                wr_gray <= wr_bin_nxt ^ (wr_bin_nxt >> 1);
            end
            rd_gray_s1 <= rd_gray;
            rd_gray_s2 <= rd_gray_s1;
        end
    end

    // Read side is held in reset for as long as the synchronised write-side reset is seen.
    always_ff @(posedge rd_clk) begin
        rd_rst_s1 <= wr_rst;
        rd_rst    <= rd_rst_s1;
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_bin     <= '0;
            rd_gray    <= '0;
            wr_gray_s1 <= '0;
            wr_gray_s2 <= '0;
        end else begin
            if (rd_rdy && !rd_empty) begin
                rd_bin  <= rd_bin_nxt;
                rd_gray <= rd_bin_nxt ^ (rd_bin_nxt >> 1);
            end
            wr_gray_s1 <= wr_gray;
            wr_gray_s2 <= wr_gray_s1;
        end
    end

    assign rd_empty = rd_rst || (rd_gray == wr_gray_s2);
    assign rd_dat   = mem[rd_bin[AW-1:0]];
endmodule

// Frame fetch FSM: one outstanding 16-word NPI read burst at a time, pushed into the local FIFO.
// Latency: frame_start reaches the FSM after a 2-FF sync plus edge detect (about 3 dram_clk).
// Backpressure: CHECK waits for 16 free local slots; pix_rd_en pops only when not pix_empty.
module dram_read_frame #(
    parameter int C_PI_ADDR_WIDTH     = 32,
    parameter int C_PI_DATA_WIDTH     = 64,
    parameter int C_PI_BE_WIDTH       = 8,
    parameter int C_PI_RDWDADDR_WIDTH = 4,
    parameter int FRAME_BURSTS        = 15000,
    parameter int FIFO_DEPTH          = 512
) (
    input  logic                           rst,
    input  logic                           dram_clk,
    input  logic                           pix_clk,
    input  logic                           frame_start,
    input  logic [C_PI_ADDR_WIDTH-1:0]     start_addr,
    input  logic                           pix_rd_en,
    output logic [C_PI_DATA_WIDTH-1:0]     pix_data,
    output logic                           pix_empty,
    output logic                           frame_done,
    output logic [C_PI_ADDR_WIDTH-1:0]     XIL_NPI_Addr,
    output logic                           XIL_NPI_AddrReq,
    input  logic                           XIL_NPI_AddrAck,
    output logic                           XIL_NPI_RNW,
    output logic [3:0]                     XIL_NPI_Size,
    input  logic [C_PI_DATA_WIDTH-1:0]     XIL_NPI_RdFIFO_Data,
    input  logic                           XIL_NPI_RdFIFO_Empty,
    input  logic [1:0]                     XIL_NPI_RdFIFO_Latency,
    output logic                           XIL_NPI_RdFIFO_Pop,
    input  logic [C_PI_RDWDADDR_WIDTH-1:0] XIL_NPI_RdFIFO_RdWdAddr,
    output logic [C_PI_DATA_WIDTH-1:0]     XIL_NPI_WrFIFO_Data,
    output logic [C_PI_BE_WIDTH-1:0]       XIL_NPI_WrFIFO_BE,
    output logic                           XIL_NPI_WrFIFO_Push,
    output logic                           XIL_NPI_WrFIFO_Flush,
    output logic                           XIL_NPI_RdFIFO_Flush,
    output logic                           XIL_NPI_RdModWr,
    input  logic                           XIL_NPI_WrFIFO_Empty,
    input  logic                           XIL_NPI_WrFIFO_AlmostFull,
    input  logic                           XIL_NPI_InitDone
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BW    = $clog2(FRAME_BURSTS + 1);

    typedef enum logic [2:0] {IDLE, CHECK, REQ, DRAIN, NEXT} state_t;

    state_t                     state, state_nxt;
    logic [2:0]                 start_sync;
    logic                       start_pulse;
    logic                       restart, restart_pend;
    logic [C_PI_ADDR_WIDTH-1:0] addr;
    logic [BW-1:0]              bursts;
    logic                       last_burst;
    logic [4:0]                 pop_cnt, push_cnt;
    logic [1:0]                 pop_dly;
    logic                       push_stb, fifo_push, fifo_rst;
    logic [3:0]                 flush_cnt;
    logic [CNT_W-1:0]           fifo_wr_cnt;
    logic                       unused_ok;

    assign unused_ok = ^{XIL_NPI_RdFIFO_RdWdAddr, XIL_NPI_WrFIFO_Empty, XIL_NPI_WrFIFO_AlmostFull};

    assign XIL_NPI_Addr         = addr;
    assign XIL_NPI_RNW          = 1'b1;
    assign XIL_NPI_Size         = 4'h4;
    assign XIL_NPI_WrFIFO_Data  = '0;
    assign XIL_NPI_WrFIFO_BE    = '0;
    assign XIL_NPI_WrFIFO_Push  = 1'b0;
    assign XIL_NPI_WrFIFO_Flush = 1'b0;
    assign XIL_NPI_RdFIFO_Flush = 1'b0;
    assign XIL_NPI_RdModWr      = 1'b0;

    always_ff @(posedge dram_clk) begin
        if (rst) start_sync <= '0;
        else     start_sync <= {start_sync[1:0], frame_start};
    end
    assign start_pulse = start_sync[1] & ~start_sync[2];
    assign last_burst  = (bursts == BW'(FRAME_BURSTS - 1));

    // An accepted NPI burst can never be abandoned, so a restart only happens outside DRAIN.
    always_comb begin
        restart = 1'b0;
        if (XIL_NPI_InitDone) begin
            case (state)
                CHECK:   restart = start_pulse;
                REQ:     restart = start_pulse & ~XIL_NPI_AddrAck;
                NEXT:    restart = start_pulse | restart_pend;
                default: restart = 1'b0;
            endcase
        end
    end

    always_ff @(posedge dram_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!XIL_NPI_InitDone) begin
            state_nxt = IDLE;
        end else if (restart) begin
            state_nxt = CHECK;
        end else begin
            case (state)
                IDLE:    if (start_pulse) state_nxt = CHECK;
                CHECK:   if (!fifo_rst && fifo_wr_cnt <= CNT_W'(FIFO_DEPTH - 16)) state_nxt = REQ;
                REQ:     if (XIL_NPI_AddrAck) state_nxt = DRAIN;
                DRAIN:   if (push_cnt == 5'd16) state_nxt = NEXT;
                NEXT:    state_nxt = last_burst ? IDLE : CHECK;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        XIL_NPI_AddrReq    = XIL_NPI_InitDone && (state == REQ);
        XIL_NPI_RdFIFO_Pop = XIL_NPI_InitDone && (state == DRAIN) && !XIL_NPI_RdFIFO_Empty
                             && (pop_cnt < 5'd16);
        frame_done         = XIL_NPI_InitDone && (state == NEXT) && !restart && last_burst;
    end

    always_comb begin
        case (XIL_NPI_RdFIFO_Latency)
            2'd0:    push_stb = XIL_NPI_RdFIFO_Pop;
            2'd1:    push_stb = pop_dly[0];
            default: push_stb = pop_dly[1];
        endcase
    end
    assign fifo_push = push_stb && (state == DRAIN);

    always_ff @(posedge dram_clk) begin
        if (rst) begin
            addr         <= '0;
            bursts       <= '0;
            pop_cnt      <= '0;
            push_cnt     <= '0;
            pop_dly      <= '0;
            restart_pend <= 1'b0;
        end else begin
            pop_dly <= {pop_dly[0], XIL_NPI_RdFIFO_Pop};
            if (!XIL_NPI_InitDone) begin
                restart_pend <= 1'b0;
            end else if (restart || (state == IDLE && start_pulse)) begin
                addr         <= start_addr;
                bursts       <= '0;
                restart_pend <= 1'b0;
            end else begin
                case (state)
                    REQ: if (XIL_NPI_AddrAck) begin
                        pop_cnt      <= '0;
                        push_cnt     <= '0;
                        restart_pend <= start_pulse;
                    end
                    DRAIN: begin
                        if (XIL_NPI_RdFIFO_Pop) pop_cnt <= pop_cnt + 1'b1;
                        if (fifo_push) push_cnt <= push_cnt + 1'b1;
                        if (start_pulse) restart_pend <= 1'b1;
                    end
                    NEXT: begin
                        addr   <= addr + C_PI_ADDR_WIDTH'(128);
                        bursts <= bursts + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stretch the flush so the slower pixel-side reset synchroniser is guaranteed to see it.
    always_ff @(posedge dram_clk) begin
        if (rst || !XIL_NPI_InitDone || restart) flush_cnt <= '1;
        else if (flush_cnt != 4'd0)              flush_cnt <= flush_cnt - 1'b1;
    end
    assign fifo_rst = rst || !XIL_NPI_InitDone || restart || (flush_cnt != 4'd0);

    dram_read_frame_fifo #(
        .W     (C_PI_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .wr_clk   (dram_clk),
        .wr_rst   (fifo_rst),
        .wr_vld   (fifo_push),
        .wr_dat   (XIL_NPI_RdFIFO_Data),
        .wr_cnt   (fifo_wr_cnt),
        .rd_clk   (pix_clk),
        .rd_rdy   (pix_rd_en),
        .rd_dat   (pix_data),
        .rd_empty (pix_empty)
    );
endmodule

// File: tb/tb_dram_read_frame.sv
// Directed bench for dram_read_frame: MPMC read-port model, pixel-side reader and address/word scoreboard.
module tb_dram_read_frame;
    logic        dram_clk = 1'b0, pix_clk = 1'b0;
    logic        rst, frame_start, pix_rd_en, frame_done, pix_empty;
    logic [31:0] start_addr, XIL_NPI_Addr;
    logic [63:0] pix_data, XIL_NPI_RdFIFO_Data, XIL_NPI_WrFIFO_Data;
    logic        XIL_NPI_AddrReq, XIL_NPI_AddrAck, XIL_NPI_RNW, XIL_NPI_RdFIFO_Empty, XIL_NPI_RdFIFO_Pop;
    logic [3:0]  XIL_NPI_Size, XIL_NPI_RdFIFO_RdWdAddr;
    logic [1:0]  XIL_NPI_RdFIFO_Latency;
    logic [7:0]  XIL_NPI_WrFIFO_BE;
    logic        XIL_NPI_WrFIFO_Push, XIL_NPI_WrFIFO_Flush, XIL_NPI_RdFIFO_Flush, XIL_NPI_RdModWr;
    logic        XIL_NPI_WrFIFO_Empty, XIL_NPI_WrFIFO_AlmostFull, XIL_NPI_InitDone;

    always #5 dram_clk = ~dram_clk;
    always #7 pix_clk  = ~pix_clk;

    dram_read_frame #(.FRAME_BURSTS(3), .FIFO_DEPTH(32)) dut (
        .rst(rst), .dram_clk(dram_clk), .pix_clk(pix_clk), .frame_start(frame_start),
        .start_addr(start_addr), .pix_rd_en(pix_rd_en), .pix_data(pix_data), .pix_empty(pix_empty),
        .frame_done(frame_done), .XIL_NPI_Addr(XIL_NPI_Addr), .XIL_NPI_AddrReq(XIL_NPI_AddrReq),
        .XIL_NPI_AddrAck(XIL_NPI_AddrAck), .XIL_NPI_RNW(XIL_NPI_RNW), .XIL_NPI_Size(XIL_NPI_Size),
        .XIL_NPI_RdFIFO_Data(XIL_NPI_RdFIFO_Data), .XIL_NPI_RdFIFO_Empty(XIL_NPI_RdFIFO_Empty),
        .XIL_NPI_RdFIFO_Latency(XIL_NPI_RdFIFO_Latency), .XIL_NPI_RdFIFO_Pop(XIL_NPI_RdFIFO_Pop),
        .XIL_NPI_RdFIFO_RdWdAddr(XIL_NPI_RdFIFO_RdWdAddr), .XIL_NPI_WrFIFO_Data(XIL_NPI_WrFIFO_Data),
        .XIL_NPI_WrFIFO_BE(XIL_NPI_WrFIFO_BE), .XIL_NPI_WrFIFO_Push(XIL_NPI_WrFIFO_Push),
        .XIL_NPI_WrFIFO_Flush(XIL_NPI_WrFIFO_Flush), .XIL_NPI_RdFIFO_Flush(XIL_NPI_RdFIFO_Flush),
        .XIL_NPI_RdModWr(XIL_NPI_RdModWr), .XIL_NPI_WrFIFO_Empty(XIL_NPI_WrFIFO_Empty),
        .XIL_NPI_WrFIFO_AlmostFull(XIL_NPI_WrFIFO_AlmostFull), .XIL_NPI_InitDone(XIL_NPI_InitDone)
    );

    int n_checks = 0, n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // MPMC read-port model state
    logic [63:0] mq[$];
    logic [63:0] exp_words[$];
    logic [31:0] exp_addrs[$];
    logic [63:0] pipe1 = '0, pipe2 = '0;
    logic [31:0] req_addr = '0;
    bit          req_prev = 1'b0, burst_open = 1'b0, rand_empty = 1'b0;
    int          lat_cfg = 0, ack_dly = 0, hold_cfg = 0, hold_cnt = 0, ack_wait = 0;
    int          burst_pops = 0, over_pop = 0, addr_unstable = 0, accepts = 0, done_cnt = 0;

    always @(posedge dram_clk) begin
        if (rst) begin
            mq.delete();
            pipe1 = '0; pipe2 = '0; ack_wait = 0; hold_cnt = 0;
            burst_open = 1'b0; req_prev = 1'b0;
        end else begin
            pipe2 = pipe1;
            pipe1 = '0;
            if (hold_cnt > 0) hold_cnt--;
            if (XIL_NPI_RdFIFO_Pop) begin
                burst_pops++;
                if (XIL_NPI_RdFIFO_Empty || mq.size() == 0) over_pop++;
                else pipe1 = mq.pop_front();
            end
            if (XIL_NPI_AddrReq && req_prev && XIL_NPI_Addr != req_addr) addr_unstable++;
            req_prev = XIL_NPI_AddrReq && !XIL_NPI_AddrAck;
            req_addr = XIL_NPI_Addr;
            if (XIL_NPI_AddrReq && XIL_NPI_AddrAck) begin
                if (burst_open) check_val("burst_pops", 64'(burst_pops), 64'd16);
                check_val("npi_addr", {32'h0, XIL_NPI_Addr},
                          {32'h0, (exp_addrs.size() != 0) ? exp_addrs.pop_front() : 32'hFFFF_FFFF});
                burst_open = 1'b1; burst_pops = 0; ack_wait = 0; hold_cnt = hold_cfg;
                accepts++;
                for (int i = 0; i < 16; i++) mq.push_back({XIL_NPI_Addr, 32'(i)});
            end else if (XIL_NPI_AddrReq) begin
                ack_wait++;
            end
            if (frame_done) done_cnt++;
        end
    end

    always @(negedge dram_clk) begin
        XIL_NPI_AddrAck      = XIL_NPI_AddrReq && (ack_wait >= ack_dly);
        XIL_NPI_RdFIFO_Empty = (mq.size() == 0) || (hold_cnt > 0)
                               || (rand_empty && $urandom_range(0, 2) == 0);
        case (lat_cfg)
            0:       XIL_NPI_RdFIFO_Data = (mq.size() != 0) ? mq[0] : '0;
            1:       XIL_NPI_RdFIFO_Data = pipe1;
            default: XIL_NPI_RdFIFO_Data = pipe2;
        endcase
    end

    always @(posedge pix_clk) begin
        logic [63:0] exp_w;
        if (pix_rd_en && !pix_empty) begin
            exp_w = (exp_words.size() != 0) ? exp_words.pop_front() : '1;
            check_val("pix_word", pix_data, exp_w);
        end
    end

    task automatic set_cfg(input int lat, input bit rnd, input int ackd, input int hold);
        @(negedge dram_clk);
        lat_cfg = lat; rand_empty = rnd; ack_dly = ackd; hold_cfg = hold;
        XIL_NPI_RdFIFO_Latency = 2'(lat);
    endtask

    task automatic load_expect(input logic [31:0] base);
        for (int b = 0; b < 3; b++) begin
            exp_addrs.push_back(base + 32'(128 * b));
            for (int i = 0; i < 16; i++) exp_words.push_back({base + 32'(128 * b), 32'(i)});
        end
    endtask

    task automatic pulse_start(input logic [31:0] base);
        @(negedge pix_clk);
        start_addr  = base;
        frame_start = 1'b1;
        repeat (3) @(negedge pix_clk);
        frame_start = 1'b0;
    endtask

    task automatic set_reader(input logic en);
        @(negedge pix_clk);
        pix_rd_en = en;
    endtask

    task automatic wait_accepts(input string tag, input int target);
        int n = 0;
        while (accepts < target && n < 2000) begin
            @(negedge dram_clk);
            n++;
        end
        check_val(tag, 64'(accepts), 64'(target));
    endtask

    task automatic wait_frame(input string tag, input int target);
        int n = 0;
        while ((done_cnt < target || exp_words.size() != 0) && n < 4000) begin
            @(negedge dram_clk);
            n++;
        end
        repeat (30) @(negedge dram_clk);
        check_val({tag, "_done"}, 64'(done_cnt), 64'(target));
        check_val({tag, "_words_left"}, 64'(exp_words.size()), 64'd0);
        check_val({tag, "_addrs_left"}, 64'(exp_addrs.size()), 64'd0);
        check_val({tag, "_idle_req"}, {63'd0, XIL_NPI_AddrReq}, 64'd0);
    endtask

    initial begin
        int a0;
        rst = 1'b1; frame_start = 1'b0; start_addr = '0; pix_rd_en = 1'b0;
        XIL_NPI_InitDone = 1'b0; XIL_NPI_RdFIFO_Latency = 2'd0; XIL_NPI_RdFIFO_RdWdAddr = '0;
        XIL_NPI_WrFIFO_Empty = 1'b1; XIL_NPI_WrFIFO_AlmostFull = 1'b0;
        XIL_NPI_AddrAck = 1'b0; XIL_NPI_RdFIFO_Empty = 1'b1; XIL_NPI_RdFIFO_Data = '0;
        repeat (20) @(negedge dram_clk);
        check_val("rst_addr_req", {63'd0, XIL_NPI_AddrReq}, 64'd0);
        check_val("rst_pop", {63'd0, XIL_NPI_RdFIFO_Pop}, 64'd0);
        check_val("rst_addr", {32'd0, XIL_NPI_Addr}, 64'd0);
        check_val("rst_frame_done", {63'd0, frame_done}, 64'd0);
        check_val("rst_pix_empty", {63'd0, pix_empty}, 64'd1);
        check_val("const_rnw_size", {59'd0, XIL_NPI_RNW, XIL_NPI_Size}, 64'h14);
        rst = 1'b0;

        // Calibration not done: a start request must be ignored.
        pulse_start(32'h1000_0000);
        repeat (60) @(negedge dram_clk);
        check_val("nocal_accepts", 64'(accepts), 64'd0);
        check_val("nocal_req", {63'd0, XIL_NPI_AddrReq}, 64'd0);
        XIL_NPI_InitDone = 1'b1;
        repeat (30) @(negedge dram_clk);

        // Latency 0, MPMC never empty: three bursts in address order.
        set_cfg(0, 1'b0, 0, 0);
        set_reader(1'b1);
        load_expect(32'h1000_0000);
        pulse_start(32'h1000_0000);
        wait_frame("lat0", 1);
        check_val("lat0_accepts", 64'(accepts), 64'd3);

        // Latency 1 and 2 with random MPMC empty gaps.
        set_cfg(1, 1'b1, 0, 0);
        load_expect(32'h2000_0000);
        pulse_start(32'h2000_0000);
        wait_frame("lat1", 2);
        set_cfg(2, 1'b1, 0, 0);
        load_expect(32'h3000_0000);
        pulse_start(32'h3000_0000);
        wait_frame("lat2", 3);

        // Reader stalled: third burst must wait in CHECK until the FIFO drains.
        set_cfg(0, 1'b0, 0, 0);
        set_reader(1'b0);
        a0 = accepts;
        load_expect(32'h4000_0000);
        pulse_start(32'h4000_0000);
        repeat (300) @(negedge dram_clk);
        check_val("bp_accepts", 64'(accepts - a0), 64'd2);
        check_val("bp_done", 64'(done_cnt), 64'd3);
        check_val("bp_req", {63'd0, XIL_NPI_AddrReq}, 64'd0);
        set_reader(1'b1);
        wait_frame("bp", 4);

        // Slow AddrAck: request must hold steady for the whole wait.
        set_cfg(0, 1'b0, 10, 0);
        load_expect(32'h5000_0000);
        pulse_start(32'h5000_0000);
        wait_frame("ackdly", 5);
        check_val("ackdly_stable", 64'(addr_unstable), 64'd0);

        // New frame_start while a burst drains: burst completes, then fetch restarts at new base.
        set_cfg(2, 1'b0, 0, 30);
        set_reader(1'b0);
        a0 = accepts;
        exp_addrs.push_back(32'h6000_0000);
        pulse_start(32'h6000_0000);
        wait_accepts("rs_first_accept", a0 + 1);
        load_expect(32'h7000_0000);
        pulse_start(32'h7000_0000);
        wait_accepts("rs_second_accept", a0 + 2);
        set_reader(1'b1);
        wait_frame("restart", 6);

        // Reset in the middle of a burst.
        set_cfg(0, 1'b0, 0, 5);
        set_reader(1'b0);
        a0 = accepts;
        exp_addrs.push_back(32'h8000_0000);
        pulse_start(32'h8000_0000);
        wait_accepts("rst_accept", a0 + 1);
        repeat (8) @(negedge dram_clk);
        rst = 1'b1;
        @(posedge dram_clk);
        #1;
        check_val("midrst_req", {63'd0, XIL_NPI_AddrReq}, 64'd0);
        check_val("midrst_pop", {63'd0, XIL_NPI_RdFIFO_Pop}, 64'd0);
        repeat (10) @(negedge pix_clk);
        check_val("midrst_pix_empty", {63'd0, pix_empty}, 64'd1);
        @(negedge dram_clk);
        rst = 1'b0;
        repeat (40) @(negedge dram_clk);
        check_val("postrst_req", {63'd0, XIL_NPI_AddrReq}, 64'd0);
        check_val("postrst_accepts", 64'(accepts - a0), 64'd1);
        check_val("over_pop", 64'(over_pop), 64'd0);
        check_val("addr_stable_all", 64'(addr_unstable), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
